sram_param: RTL and testbench

Parametrised single-port synchronous SRAM that succeeds the fixed 16x16 RAM. It adds configurable width and depth, per-byte write enables, and a req/ready/rvalid handshake. A hardware clear sequencer initialises every word after reset or on command. It sits between a bus-side controller and on-chip block RAM wherever initialised, byte-writable scratch storage is needed.

---
 rtl/sram_param_if.sv | 26 ++
 rtl/sram_param.sv | 134 +++++++++++++
 tb/tb_sram_param.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_param_if.sv
// Bus-side interface of sram_param: request/handshake signals plus read return.
// The controller uses the master modport; the SRAM uses the slave modport.
interface sram_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                  clr;
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     data_out;

  modport master (
    output clr, req, we, be, addr, data_in,
    input  ready, rvalid, data_out
  );

  modport slave (
    input  clr, req, we, be, addr, data_in,
    output ready, rvalid, data_out
  );
endinterface

// File: rtl/sram_param.sv
// sram_param: parametrised single-port synchronous SRAM with per-byte write
// enables, req/ready/rvalid handshake and a hardware clear sequencer that
// writes INIT_VAL to every word after reset or on a clr pulse.
// Optional build macro SRAM_PARAM_OUTREG_EN adds an output register stage
// after the RAM (read latency 2 instead of 1).
module sram_param #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic        clk,
  input logic        rst,
  sram_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                rd_accept;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NB-1:0]       wr_be;

  logic [ADDR_W-1:0]   rd_addr_p0;
  logic                vld_p0;
  logic [DATA_W-1:0]   data_p1;
  logic                vld_p1;

  // ready is the state flop itself (RUN encodes as 1), so it is registered.
  assign bus.ready = (state == RUN);
  // A request coinciding with clr or rst is never accepted.
  assign accept    = bus.req & bus.ready & ~bus.clr & ~rst;
  assign rd_accept = accept & ~bus.we;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Next state: CLEAR runs until the last word is written; clr in RUN restarts it.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_next = RUN;
      RUN:     if (bus.clr) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Clear counter: parked at 0 in RUN so every clear sequence starts at word 0.
  always_ff @(posedge clk) begin
    if (rst || state == RUN) clr_cnt <= '0;
    else                     clr_cnt <= clr_cnt + 1'b1;
  end

  // Single write port shared between the clear sequencer and bus writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.addr;
    wr_data = bus.data_in;
    wr_be   = bus.be;
    if (state == CLEAR && !rst) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = INIT_VAL;
      wr_be   = '1;
    end else if (accept && bus.we) begin
      wr_en   = 1'b1;
    end
  end

  // Memory array with byte-lane write enables.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Stage p0: capture read address of an accepted read (registered-address RAM).
  always_ff @(posedge clk) begin
    if (rd_accept) rd_addr_p0 <= bus.addr;
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd_accept;
  end

  // Stage p1: RAM data register; holds the last read word between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) data_p1 <= mem[rd_addr_p0];
    end
  end

`ifdef SRAM_PARAM_OUTREG_EN
  logic [DATA_W-1:0]   data_p2;
  logic                vld_p2;

  // Stage p2: extra output register, one more cycle of latency at full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= data_p1;
    end
  end

  assign bus.rvalid   = vld_p2;
  assign bus.data_out = data_p2;
`else
  assign bus.rvalid   = vld_p1;
  assign bus.data_out = data_p1;
`endif

endmodule

// File: tb/tb_sram_param.sv
// Testbench for sram_param: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural memory model kept in the bench.
module tb_sram_param;

  localparam int          DEPTH = 16;
  localparam logic [15:0] INIT  = 16'hA5A5;
`ifdef SRAM_PARAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_param_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  sram_param_if #(.DATA_W(32), .ADDR_W(6)) wbus ();

  sram_param #(.DATA_W(16), .ADDR_W(4), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  sram_param #(.DATA_W(32), .ADDR_W(6), .INIT_VAL(32'h0)) dut_w (
    .clk(clk), .rst(rst), .bus(wbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int          due;
    logic [15:0] d;
  } rd_t;

  logic [15:0] mem_m [DEPTH];
  rd_t         q[$];
  int          clr_left = 0;
  int          cyc = 0;
  bit          live = 0;
  bit          exp_rv;
  logic [15:0] dout_m = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      live     = 1;
      clr_left = DEPTH;
      q.delete();
      dout_m   = '0;
    end else if (live) begin
      if (clr_left > 0) begin
        mem_m[DEPTH - clr_left] = INIT;
        clr_left--;
      end else if (bus.clr) begin
        clr_left = DEPTH;
      end else if (bus.req) begin
        if (bus.we) begin
          for (int i = 0; i < 2; i++)
            if (bus.be[i]) mem_m[bus.addr][8*i +: 8] = bus.data_in[8*i +: 8];
        end else begin
          q.push_back('{due: cyc + LAT, d: mem_m[bus.addr]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      exp_rv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rv = 1;
        dout_m = q[0].d;
        void'(q.pop_front());
      end
      chk("ready", bus.ready, clr_left == 0);
      chk("rvalid", bus.rvalid, exp_rv);
      chk("data_out", bus.data_out, dout_m);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ready(input string name, input int exp_n);
    int n = 0;
    bit saw_rv = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.rvalid === 1'b1) saw_rv = 1;
    end
    chk(name, n, exp_n);
    chk({name, "_rvalid"}, saw_rv, 0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    bus.req = 1; bus.we = 1; bus.addr = a; bus.data_in = d; bus.be = b;
    @(negedge clk);
    bus.req = 0; bus.we = 0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string name);
    int n = 0;
    bus.req = 1; bus.we = 0; bus.addr = a;
    @(negedge clk);
    bus.req = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rvalid !== 1'b1 && n < 5);
    chk({name, "_lat"}, n, LAT);
    chk({name, "_data"}, bus.data_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got, first, last, k;
    rst = 1;
    bus.clr = 0; bus.req = 0; bus.we = 0; bus.be = '0; bus.addr = '0; bus.data_in = '0;
    wbus.clr = 0; wbus.req = 0; wbus.we = 0; wbus.be = '0; wbus.addr = '0; wbus.data_in = '0;

    // Reset / clear: ready 16 cycles after release, all words INIT.
    @(negedge clk);
    chk("rst_ready", bus.ready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_dout", bus.data_out, 0);
    rst = 0;
    wait_ready("ready_after_rst", 16);
    for (int a = 0; a < DEPTH; a++) do_read(4'(a), INIT, "init_read");

    // Byte enables.
    do_write(4'd3, 16'h1234, 2'b11);
    do_write(4'd3, 16'hFF00, 2'b01);
    do_read(4'd3, 16'h1200, "be_read");
    @(negedge clk);
    chk("be_single_pulse", bus.rvalid, 0);
    chk("model_be", mem_m[3], 16'h1200);

    // Streaming: 16 writes, then 16 back-to-back reads.
    for (int a = 0; a < DEPTH; a++) do_write(4'(a), 16'(a * 16'h0101), 2'b11);
    got = 0; first = -1; last = -1;
    for (int i = 0; i < DEPTH + LAT + 2; i++) begin
      bus.req = (i < DEPTH); bus.we = 0; bus.addr = 4'(i);
      @(negedge clk);
      if (bus.rvalid === 1'b1) begin
        chk("stream_data", bus.data_out, 16'(got * 16'h0101));
        if (first < 0) first = i;
        last = i;
        got++;
      end
    end
    bus.req = 0;
    chk("stream_count", got, 16);
    chk("stream_consecutive", last - first + 1, 16);

    // Clear collision: write with clr in the same cycle is dropped.
    bus.req = 1; bus.we = 1; bus.addr = 4'd5; bus.data_in = 16'hBEEF; bus.be = 2'b11; bus.clr = 1;
    @(negedge clk);
    bus.req = 0; bus.we = 0; bus.clr = 0;
    chk("collision_ready_low", bus.ready, 0);
    wait_ready("collision_ready", 16);
    do_read(4'd5, INIT, "collision_read");
    chk("model_clr", mem_m[5], INIT);

    // Read in flight across a clr edge still completes.
    do_write(4'd7, 16'h0707, 2'b11);
    bus.req = 1; bus.we = 0; bus.addr = 4'd7;
    @(negedge clk);
    bus.req = 0; bus.clr = 1;
    @(negedge clk);
    bus.clr = 0;
    k = 1;
    while (bus.rvalid !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("clr_inflight_lat", k, LAT);
    chk("clr_inflight_data", bus.data_out, 16'h0707);
    wait_ready("clr_inflight_ready", 17 - k);

    // Reset at clear counter 7: sequence restarts from address 0.
    do_write(4'd0, 16'h1111, 2'b11);
    bus.clr = 1;
    @(negedge clk);
    bus.clr = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    wait_ready("midclear_ready", 16);
    do_read(4'd0, INIT, "midclear_read");

    // Randomized traffic checked by the model.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bus.clr     = ($urandom_range(0, 49) == 0);
      bus.req     = $urandom_range(0, 1);
      bus.we      = $urandom_range(0, 1);
      bus.be      = 2'($urandom);
      bus.addr    = 4'($urandom);
      bus.data_in = 16'($urandom);
      @(negedge clk);
    end
    rst = 0; bus.clr = 0; bus.req = 0;
    repeat (LAT + 2) @(negedge clk);

    // Wider configuration: 32-bit words, 64 entries, INIT 0.
    got = 0;
    while (wbus.ready !== 1'b1 && got < 200) begin
      @(negedge clk);
      got++;
    end
    chk("wide_ready", wbus.ready, 1);
    wbus.req = 1; wbus.we = 1; wbus.addr = 6'd63; wbus.data_in = 32'hDEADBEEF; wbus.be = 4'b1010;
    @(negedge clk);
    wbus.we = 0; wbus.addr = 6'd63;
    @(negedge clk);
    wbus.req = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (wbus.rvalid !== 1'b1 && k < 5);
    chk("wide_lat", k, LAT);
    chk("wide_data", wbus.data_out, 32'hDE00BE00);
    wbus.req = 1; wbus.addr = 6'd62;
    @(negedge clk);
    wbus.req = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (wbus.rvalid !== 1'b1 && k < 5);
    chk("wide_init_data", wbus.data_out, 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
